// File: rtl/page_walker.sv
`timescale 1ns/1ps
// Sv48 hardware page-table walker: turns a TLB miss into a sequence of PTE reads
// and returns the leaf translation (or a zeroed fault result) as a one-cycle pulse.
module page_walker #(
  parameter int VA_BITS   = 48,
  parameter int PTE_BYTES = 8,
  parameter int LEVELS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [43:0] satp_ppn,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  output logic [63:0] resp_addr,
  output logic [7:0]  resp_perm_bits,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data
);

  localparam int VPN_BITS  = VA_BITS - 12;
  localparam int PTE_SHIFT = $clog2(PTE_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    HOLD  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  function automatic logic [8:0] vpn_index(input logic [1:0] lvl, input logic [VPN_BITS-1:0] vpn);
    case (lvl)
      2'd0:    vpn_index = vpn[8:0];
      2'd1:    vpn_index = vpn[17:9];
      2'd2:    vpn_index = vpn[26:18];
      2'd3:    vpn_index = vpn[35:27];
      default: vpn_index = 9'd0;
    endcase
  endfunction

  // PPN bits that a leaf at this level takes from the VA instead of the PTE
  function automatic logic [43:0] page_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    page_mask = 44'h0;
      2'd1:    page_mask = 44'h1FF;
      2'd2:    page_mask = 44'h3FFFF;
      2'd3:    page_mask = 44'h7FFFFFF;
      default: page_mask = 44'h0;
    endcase
  endfunction

  function automatic logic [63:0] pte_addr(input logic [43:0] ppn, input logic [8:0] idx);
    pte_addr = {8'd0, ppn, 12'd0} + ({55'd0, idx} << PTE_SHIFT);
  endfunction

  state_t              state, state_n;
  logic [1:0]          level, level_n;
  logic [VPN_BITS-1:0] va_q, va_n;
  logic [43:0]         ppn_q, ppn_n;
  logic                res_load;
  logic [63:0]         res_addr;
  logic [7:0]          res_perm;

  logic        pte_v, pte_r, pte_w, pte_x;
  logic        pte_leaf, pte_bad, pte_misaligned;
  logic [43:0] pte_ppn, lvl_mask, leaf_ppn;
  logic        unused_bits;

  assign pte_v          = mem_resp_data[0];
  assign pte_r          = mem_resp_data[1];
  assign pte_w          = mem_resp_data[2];
  assign pte_x          = mem_resp_data[3];
  assign pte_ppn        = mem_resp_data[53:10];
  assign pte_leaf       = pte_r | pte_x;
  assign pte_bad        = !pte_v || (!pte_r && pte_w) || (mem_resp_data[63:54] != 10'd0);
  assign lvl_mask       = page_mask(level);
  assign pte_misaligned = (pte_ppn & lvl_mask) != 44'd0;
  assign leaf_ppn       = (pte_ppn & ~lvl_mask) | ({8'd0, va_q} & lvl_mask);
  assign unused_bits    = ^{req_addr[63:VA_BITS], req_addr[11:0], mem_resp_data[9:8]};

  // Next-state, walk context and result computation
  always_comb begin
    state_n  = state;
    level_n  = level;
    ppn_n    = ppn_q;
    va_n     = va_q;
    res_load = 1'b0;
    res_addr = 64'd0;
    res_perm = 8'd0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (req_valid) begin
          state_n = ISSUE;
          va_n    = req_addr[VA_BITS-1:12];
          ppn_n   = satp_ppn;
          level_n = 2'(LEVELS - 1);
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        // A request accepted in the flush cycle still owes a response; drain it.
        if (flush) begin
          state_n = mem_req_ready ? DRAIN : IDLE;
        end else if (mem_req_ready) begin
          state_n = WAIT;
        end else begin
          state_n = ISSUE;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (flush) begin
            state_n = IDLE;
          end else if (pte_bad || (pte_leaf && pte_misaligned) || (!pte_leaf && level == 2'd0)) begin
            state_n  = RESP;
            res_load = 1'b1;
          end else if (pte_leaf) begin
            state_n  = RESP;
            res_load = 1'b1;
            res_addr = {8'd0, leaf_ppn, 12'd0};
            res_perm = mem_resp_data[7:0];
          end else begin
            state_n = ISSUE;
            ppn_n   = pte_ppn;
            level_n = level - 2'd1;
          end
        end else if (flush) begin
          state_n = DRAIN;
        end else begin
          state_n = WAIT;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      RESP:    state_n = HOLD;
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Walk state and context registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      level <= 2'(LEVELS - 1);
      va_q  <= '0;
      ppn_q <= 44'd0;
    end else begin
      state <= state_n;
      level <= level_n;
      va_q  <= va_n;
      ppn_q <= ppn_n;
    end
  end

  // Registered outputs, computed from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid     <= 1'b0;
      resp_addr      <= 64'd0;
      resp_perm_bits <= 8'd0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= 64'd0;
    end else begin
      resp_valid    <= (state_n == RESP);
      mem_req_valid <= (state_n == ISSUE);
      if (res_load) begin
        resp_addr      <= res_addr;
        resp_perm_bits <= res_perm;
      end else begin
        resp_addr      <= resp_addr;
        resp_perm_bits <= resp_perm_bits;
      end
      if (state_n == ISSUE) begin
        mem_req_addr <= pte_addr(ppn_n, vpn_index(level_n, va_n));
      end else begin
        mem_req_addr <= mem_req_addr;
      end
    end
  end

endmodule

// File: tb/tb_page_walker.sv
`timescale 1ns/1ps
// Bench for page_walker: table of directed walks, hand-written flush/reset/backpressure
// sequences and random walks checked against an arithmetic page-table walk model.
module tb_page_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic [43:0] satp_ppn;
  logic        flush;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_addr;
  logic [7:0]  resp_perm_bits;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  always #5 clk = ~clk;

  page_walker dut (
    .clk(clk), .reset(reset), .satp_ppn(satp_ppn), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .resp_valid(resp_valid),
    .resp_addr(resp_addr), .resp_perm_bits(resp_perm_bits),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic [43:0]      satp;
    logic [63:0]      va;
    logic [3:0][63:0] pte;
    logic [63:0]      e_addr;
    logic [7:0]       e_perm;
    int               e_n;
    logic [63:0]      e_first;
  } vec_t;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } pend_t;

  int          passed = 0;
  int          total  = 0;
  int          resp_delay = 1;
  int          tick = 0;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] reads[$];
  logic [63:0] exp_reads[$];
  pend_t       pend[$];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [63:0] nl(logic [43:0] ppn);
    return {10'd0, ppn, 10'h001};
  endfunction

  function automatic logic [63:0] lf(logic [43:0] ppn, logic [7:0] bits);
    return {10'd0, ppn, 2'b00, bits};
  endfunction

  function automatic logic [63:0] slot(logic [63:0] ppn, logic [63:0] va, int lvl);
    return ppn * 64'd4096 + ((va >> (12 + 9 * lvl)) % 64'd512) * 64'd8;
  endfunction

  // Reference walk: plain arithmetic over the memory image
  function automatic void ref_walk(input logic [43:0] satp, input logic [63:0] va,
                                   output logic [63:0] eaddr, output logic [7:0] eperm, output int n);
    logic [63:0] ppn, vpn, a, pte, pp, span;
    ppn = 64'(satp);
    vpn = (va >> 12) % (64'd1 << 36);
    eaddr = 64'd0; eperm = 8'd0; n = 0;
    exp_reads.delete();
    for (int lvl = 3; lvl >= 0; lvl--) begin
      a = slot(ppn, va, lvl);
      exp_reads.push_back(a);
      n++;
      pte = mem.exists(a) ? mem[a] : 64'd0;
      if (pte[0] == 1'b0 || (pte[2] && !pte[1]) || (pte >> 54) != 64'd0) return;
      pp = (pte >> 10) % (64'd1 << 44);
      if (pte[1] || pte[3]) begin
        span = 64'd1 << (9 * lvl);
        if (pp % span != 64'd0) return;
        eaddr = (pp + vpn % span) << 12;
        eperm = pte[7:0];
        return;
      end
      if (lvl == 0) return;
      ppn = pp;
    end
  endfunction

  function automatic void install(vec_t v);
    logic [63:0] ppn, a;
    ppn = 64'(v.satp);
    for (int lvl = 3; lvl > 3 - v.e_n; lvl--) begin
      a = slot(ppn, v.va, lvl);
      mem[a] = v.pte[lvl];
      ppn = 64'(v.pte[lvl][53:10]);
    end
  endfunction

  // Memory: one response per accepted request, resp_delay cycles after acceptance
  initial begin
    logic acc;
    logic [63:0] a;
    pend_t pe;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'd0;
    forever begin
      @(negedge clk);
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      @(posedge clk); #1;
      tick++;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 64'd0;
      if (acc) begin
        reads.push_back(a);
        pend.push_back('{tick + resp_delay - 1, a});
      end
      if (pend.size() > 0 && pend[0].due <= tick) begin
        pe = pend.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem.exists(pe.addr) ? mem[pe.addr] : 64'd0;
      end
    end
  end

  task automatic do_walk(string tag, logic [43:0] satp, logic [63:0] va, int stall, bit hold,
                         output logic [63:0] g_addr, output logic [7:0] g_perm, output int g_n);
    logic [63:0] ea, a0;
    logic [7:0]  ep;
    int en, lat, cnt;
    bit seen;
    ref_walk(satp, va, ea, ep, en);
    reads.delete();
    satp_ppn = satp; req_addr = va; req_valid = 1'b1;
    mem_req_ready = (stall == 0);
    lat = 1; seen = 1'b0; a0 = 64'd0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (k == 1) begin
        a0 = mem_req_addr;
        chk({tag, " first addr"}, mem_req_addr, exp_reads[0]);
      end
      if (stall > 0 && k <= stall + 1) begin
        chk({tag, " held valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, " addr stable"}, mem_req_addr, a0);
      end
      if (k == stall + 1) mem_req_ready = 1'b1;
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) chk({tag, " timeout"}, 64'd0, 64'd1);
    g_addr = resp_addr; g_perm = resp_perm_bits; g_n = reads.size();
    chk({tag, " addr"}, resp_addr, ea);
    chk({tag, " perm"}, 64'(resp_perm_bits), 64'(ep));
    chk({tag, " latency"}, 64'(lat), 64'(2 * en + 2 + stall));
    chk({tag, " nreads"}, 64'(reads.size()), 64'(en));
    for (int i = 0; i < en; i++)
      chk($sformatf("%s read%0d", tag, i), (i < reads.size()) ? reads[i] : '1, exp_reads[i]);
    if (!hold) req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'(resp_valid), 64'd0);
    chk({tag, " stable"}, resp_addr, g_addr);
    req_valid = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      cnt += int'(resp_valid) + int'(mem_req_valid);
    end
    chk({tag, " no dup"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    logic [63:0] ga, va, pte, a, ppn, lp;
    logic [7:0]  gp, perm;
    logic [43:0] satp;
    int          gn, cnt, leaf_lvl;

    tbl[0] = '{44'h100, 64'h0000_1234_5678_9000, {nl(44'h200), nl(44'h300), nl(44'h400), lf(44'hABCDE, 8'hCF)},
               64'hABCDE000, 8'hCF, 4, 64'h100120};
    tbl[1] = '{44'h100, 64'h4_1234_5000, {nl(44'h200), lf(44'h40000, 8'hCF), 64'd0, 64'd0},
               64'h52345000, 8'hCF, 2, 64'h100000};
    tbl[2] = '{44'h100, 64'h0000_1234_5678_9000, {64'd0, 64'd0, 64'd0, 64'd0}, 64'd0, 8'd0, 1, 64'h100120};
    tbl[3] = '{44'h100, 64'h0000_1234_5678_9000, {nl(44'h200), lf(44'h300, 8'h0D), 64'd0, 64'd0},
               64'd0, 8'd0, 2, 64'h100120};
    tbl[4] = '{44'h100, 64'h0000_1234_5678_9000, {nl(44'h200), lf(44'h40001, 8'hCF), 64'd0, 64'd0},
               64'd0, 8'd0, 2, 64'h100120};
    tbl[5] = '{44'h100, 64'h0000_1234_5678_9000, {nl(44'h200), nl(44'h300), nl(44'h400), nl(44'h500)},
               64'd0, 8'd0, 4, 64'h100120};
    tbl[6] = '{44'h100, 64'h0000_1234_5678_9000,
               {nl(44'h200), nl(44'h300), lf(44'h600, 8'hCF) | 64'h8000_0000_0000_0000, 64'd0},
               64'd0, 8'd0, 3, 64'h100120};
    tbl[7] = '{44'h100, 64'h0000_1234_5678_9000, {nl(44'h200), nl(44'h300), lf(44'h600, 8'h4B), 64'd0},
               64'h789000, 8'h4B, 3, 64'h100120};

    reset = 1'b0; satp_ppn = 44'd0; flush = 1'b0; req_valid = 1'b0; req_addr = 64'd0; mem_req_ready = 1'b1;
    #12;
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_addr", resp_addr, 64'd0);
    chk("reset perm", 64'(resp_perm_bits), 64'd0);
    chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset mem_req_addr", mem_req_addr, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem.delete();
      install(tbl[i]);
      do_walk($sformatf("vec%0d", i), tbl[i].satp, tbl[i].va, 0, 1'b0, ga, gp, gn);
      chk($sformatf("vec%0d tbl addr", i), ga, tbl[i].e_addr);
      chk($sformatf("vec%0d tbl perm", i), 64'(gp), 64'(tbl[i].e_perm));
      chk($sformatf("vec%0d tbl nreads", i), 64'(gn), 64'(tbl[i].e_n));
      chk($sformatf("vec%0d tbl first", i), (reads.size() > 0) ? reads[0] : '1, tbl[i].e_first);
    end

    // Backpressure: five refused cycles on the first read
    mem.delete();
    install(tbl[0]);
    do_walk("bp", tbl[0].satp, tbl[0].va, 5, 1'b0, ga, gp, gn);
    chk("bp tbl addr", ga, tbl[0].e_addr);

    // req_valid held one cycle past resp_valid: still only one walk
    do_walk("hold", tbl[0].satp, tbl[0].va, 0, 1'b1, ga, gp, gn);
    chk("hold nreads", 64'(reads.size()), 64'd4);

    // flush and req_valid together in IDLE: no walk starts
    flush = 1'b1; req_valid = 1'b1; satp_ppn = tbl[0].satp; req_addr = tbl[0].va;
    @(posedge clk); #1;
    chk("flush idle no issue", 64'(mem_req_valid), 64'd0);
    flush = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush idle still idle", 64'(mem_req_valid), 64'd0);

    // Flush in WAIT with data arriving three cycles after acceptance
    reads.delete(); resp_delay = 3;
    req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush wait entered", 64'(mem_req_valid), 64'd0);
    flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      cnt += int'(resp_valid) + int'(mem_req_valid);
    end
    chk("flush no resp", 64'(cnt), 64'd0);
    chk("flush one read", 64'(reads.size()), 64'd1);
    chk("flush data delivered", 64'(pend.size()), 64'd0);
    resp_delay = 1;
    do_walk("after flush", tbl[0].satp, tbl[0].va, 0, 1'b0, ga, gp, gn);
    chk("after flush tbl addr", ga, tbl[0].e_addr);

    // Asynchronous reset in WAIT, response arrives after release
    reads.delete(); resp_delay = 3;
    req_valid = 1'b1; satp_ppn = tbl[0].satp; req_addr = tbl[0].va;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    chk("rst mid resp_valid", 64'(resp_valid), 64'd0);
    chk("rst mid resp_addr", resp_addr, 64'd0);
    chk("rst mid perm", 64'(resp_perm_bits), 64'd0);
    chk("rst mid mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst mid mem_req_addr", mem_req_addr, 64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      cnt += int'(resp_valid) + int'(mem_req_valid);
    end
    chk("rst late resp ignored", 64'(cnt), 64'd0);
    chk("rst late data delivered", 64'(pend.size()), 64'd0);
    resp_delay = 1;
    mem.delete();
    install(tbl[1]);
    do_walk("after rst", tbl[1].satp, tbl[1].va, 0, 1'b0, ga, gp, gn);
    chk("after rst tbl addr", ga, tbl[1].e_addr);

    // Random page tables against the reference walk
    for (int r = 0; r < 40; r++) begin
      mem.delete();
      satp = 44'($urandom_range(1, 20'hFFFFF));
      va = {$urandom, $urandom};
      leaf_lvl = $urandom_range(0, 3);
      ppn = 64'(satp);
      for (int lvl = 3; lvl >= leaf_lvl; lvl--) begin
        a = slot(ppn, va, lvl);
        if ($urandom_range(0, 9) == 0) begin
          pte = {$urandom, $urandom};
        end else if (lvl > leaf_lvl) begin
          pte = nl(44'($urandom_range(1, 20'hFFFFF)));
        end else begin
          lp = 64'(44'({$urandom, $urandom}));
          if ($urandom_range(0, 1) == 1) lp = lp - lp % (64'd1 << (9 * lvl));
          perm = 8'($urandom);
          perm[0] = 1'b1;
          if (!perm[1] && !perm[3]) perm[1] = 1'b1;
          if (perm[2] && !perm[1]) perm[1] = 1'b1;
          pte = lf(lp[43:0], perm);
        end
        mem[a] = pte;
        ppn = 64'(pte[53:10]);
      end
      do_walk($sformatf("rnd%0d", r), satp, va, $urandom_range(0, 2), 1'($urandom_range(0, 1)), ga, gp, gn);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
